// File: rtl/ws_pkg.sv
// Shared types and helpers for the weight-stationary array loader.
package ws_pkg;

    localparam int unsigned IP_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } ws_ld_state_t;

    // Beat counter width: $clog2(rows), never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned rows);
        return (rows <= 2) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/ws_weight_loader.sv
// Streams ROWS row-vectors of weights into the array top edge with a broadcast
// load strobe, then signals completion so compute only starts on a full array.
module ws_weight_loader
    import ws_pkg::*;
#(
    parameter int unsigned IP_size = IP_SIZE_DEF,
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    start_ready,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [COLS*IP_size-1:0] w_data,
    output logic                    w_load_out,
    output logic [COLS*IP_size-1:0] w_col,
    output logic                    busy,
    output logic                    done,
    output logic                    weights_valid
);

    localparam int unsigned     CW   = cnt_w(ROWS);
    localparam logic [CW-1:0]   LAST = CW'(ROWS - 1);

    ws_ld_state_t               state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       wv_q, wv_d;
    logic                       load_q, load_d;
    logic [COLS*IP_size-1:0]    col_q, col_d;
    logic                       accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wv_q    <= 1'b0;
            load_q  <= 1'b0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wv_q    <= wv_d;
            load_q  <= load_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wv_d    = wv_q;
        accept  = (state_q == ST_LOAD) && w_valid;
        // Stall cycles drive zero so the PE chain sees a clean idle top edge.
        load_d  = accept;
        col_d   = accept ? w_data : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    wv_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                wv_d    = 1'b1;
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    wv_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode registered state only.
    assign start_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_ready       = (state_q == ST_LOAD);
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign weights_valid = wv_q;
    assign w_load_out    = load_q;
    assign w_col         = col_q;

endmodule

// File: tb/tb_ws_weight_loader.sv
// Directed/randomized bench for ws_weight_loader with a PE-column shift model.
module tb_ws_weight_loader;

    localparam int W = 8;
    localparam int R = 4;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, w_valid;
    logic [C*W-1:0] w_data;
    logic           start_ready, w_ready, w_load_out, busy, done, weights_valid;
    logic [C*W-1:0] w_col;

    logic           start1, w_valid1;
    logic [C*W-1:0] w_data1;
    logic           start_ready1, w_ready1, w_load_out1, busy1, done1, weights_valid1;
    logic [C*W-1:0] w_col1;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    int             load_cnt;
    logic [C*W-1:0] pe [R];

    ws_weight_loader #(.IP_size(W), .ROWS(R), .COLS(C)) u_dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_load_out(w_load_out), .w_col(w_col), .busy(busy), .done(done),
        .weights_valid(weights_valid)
    );

    ws_weight_loader #(.IP_size(W), .ROWS(1), .COLS(C)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .start_ready(start_ready1),
        .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1),
        .w_load_out(w_load_out1), .w_col(w_col1), .busy(busy1), .done(done1),
        .weights_valid(weights_valid1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: each strobe shifts every column down one row, top row takes w_col.
    always @(negedge clk) begin
        if (w_load_out) begin
            for (int r = R - 1; r > 0; r--) pe[r] <= pe[r-1];
            pe[0]    <= w_col;
            load_cnt <= load_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full load on the ROWS=4 instance; rows[r] is the vector PE row r must hold.
    task automatic run_load(input logic [C*W-1:0] rows [R], input int gap_after,
                            input int gap_len, input bit start_mid);
        int e0;
        int gaps;
        gaps = 0;
        chk("idle_start_ready", start_ready, 1);
        start = 1'b1;
        tick();
        start    = 1'b0;
        e0       = cyc;
        load_cnt = 0;
        chk("load_wv_cleared", weights_valid, 0);
        chk("load_busy", busy, 1);
        chk("load_w_ready", w_ready, 1);
        chk("load_start_ready", start_ready, 0);
        for (int b = 0; b < R; b++) begin
            w_valid = 1'b1;
            w_data  = rows[R-1-b];
            if (start_mid && b == 1) start = 1'b1;
            tick();
            start   = 1'b0;
            w_valid = 1'b0;
            w_data  = C*W'($urandom);
            chk("beat_strobe", w_load_out, 1);
            chk("beat_col", w_col, rows[R-1-b]);
            if (b == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    gaps++;
                    chk("gap_strobe", w_load_out, 0);
                    chk("gap_col", w_col, 0);
                    chk("gap_ready", w_ready, 1);
                end
            end
        end
        chk("drain_busy", busy, 1);
        chk("drain_w_ready", w_ready, 0);
        chk("drain_done", done, 0);
        tick();
        chk("done_pulse", done, 1);
        chk("done_wv", weights_valid, 1);
        chk("done_busy", busy, 0);
        chk("done_cycle", cyc, e0 + R + 1 + gaps);
        tick();
        chk("after_done", done, 0);
        chk("after_wv_held", weights_valid, 1);
        chk("after_start_ready", start_ready, 1);
        @(negedge clk);
        #1;
        chk("strobe_count", load_cnt, R);
        for (int r = 0; r < R; r++) chk("pe_row", pe[r], rows[r]);
        tick();
    endtask

    logic [C*W-1:0] rows [R];
    int             e1;

    initial begin
        rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = '0;
        start1 = 1'b0; w_valid1 = 1'b0; w_data1 = '0;
        load_cnt = 0;
        for (int r = 0; r < R; r++) pe[r] = '0;
        tick();
        tick();
        chk("rst_strobe", w_load_out, 0);
        chk("rst_col", w_col, 0);
        chk("rst_done", done, 0);
        chk("rst_wv", weights_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Row r, column c holds {r,1}+c.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) rows[r][c*W +: W] = W'((r << 4) + 1 + c);
        run_load(rows, -1, 0, 1'b0);
        run_load(rows, 1, 3, 1'b0);

        for (int r = 0; r < R; r++) begin
            rows[r] = {8'sd0, 8'sd127, -8'sd1, -8'sd128};
            rows[r][r*W +: W] = W'(r * 37);
        end
        run_load(rows, -1, 0, 1'b0);

        for (int r = 0; r < R; r++) rows[r] = C*W'($urandom);
        run_load(rows, 2, $urandom_range(1, 4), 1'b1);

        // Reset in the middle of a load.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            w_valid = 1'b1;
            w_data  = C*W'($urandom);
            tick();
        end
        w_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_strobe", w_load_out, 0);
        chk("mid_rst_col", w_col, 0);
        chk("mid_rst_wv", weights_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_w_ready", w_ready, 0);
        chk("mid_rst_start_ready", start_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int r = 0; r < R; r++) rows[r] = C*W'($urandom);
        run_load(rows, 0, 1, 1'b0);

        // Single-row variant.
        w_data1 = C*W'($urandom);
        chk("r1_start_ready", start_ready1, 1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        e1 = cyc;
        w_valid1 = 1'b1;
        tick();
        w_valid1 = 1'b0;
        chk("r1_strobe", w_load_out1, 1);
        chk("r1_col", w_col1, w_data1);
        chk("r1_drain_ready", w_ready1, 0);
        tick();
        chk("r1_done", done1, 1);
        chk("r1_done_cycle", cyc, e1 + 2);
        chk("r1_wv", weights_valid1, 1);
        chk("r1_strobe_off", w_load_out1, 0);
        tick();
        chk("r1_done_off", done1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
